// File: rtl/day5_mult_pkg.sv
// Shared types and sizing helpers for the shift-and-add multiplier.
package day5_mult_pkg;

   typedef enum logic {
      IDLE,
      CALC
   } state_t;

   localparam int DEF_WIDTH = 4;

   // Keeps at least one counter bit so WIDTH=1 still elaborates.
   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/day5_4bit_multiplier.sv
// Sequential unsigned multiplier: one multiplier bit per clock,
// start/done handshake, operands captured at start.
module day5_4bit_multiplier
   import day5_mult_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a_in,
   input  logic [WIDTH-1:0]   b_in,
   output logic [2*WIDTH-1:0] product,
   output logic               busy,
   output logic               done
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           r_state;
   logic [PW-1:0]    r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [PW-1:0]    r_acc;
   logic [CW-1:0]    r_cnt;
   logic [PW-1:0]    r_product;
   logic             r_busy;
   logic             r_done;

   logic [PW-1:0]    w_acc_next;

   assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

   assign product = r_product;
   assign busy    = r_busy;
   assign done    = r_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_product <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  r_mcand  <= {{WIDTH{1'b0}}, a_in};
                  r_mplier <= b_in;
                  r_acc    <= '0;
                  r_cnt    <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= CALC;
               end
            end
            CALC: begin
               r_acc    <= w_acc_next;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + 1'b1;
               // Last bit: publish the sum including this bit's term.
               if (r_cnt == LAST) begin
                  r_product <= w_acc_next;
                  r_done    <= 1'b1;
                  r_busy    <= 1'b0;
                  r_state   <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_day5_4bit_multiplier.sv
// Bench for day5_4bit_multiplier: vector table, hand-written
// corner sequences and a back-to-back sweep with a result queue.
module tb_day5_4bit_multiplier;

   localparam int W = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [W-1:0]   a_in;
   logic [W-1:0]   b_in;
   logic [2*W-1:0] product;
   logic           busy;
   logic           done;

   int n_checks = 0;
   int n_fail   = 0;
   int n_done   = 0;

   logic [2*W-1:0] sb [$];

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [7:0] p;
   } vec_t;

   vec_t vecs [6];

   always #5 clk = ~clk;

   day5_4bit_multiplier #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a_in    (a_in),
      .b_in    (b_in),
      .product (product),
      .busy    (busy),
      .done    (done)
   );

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d",
                  name, act, exp);
      end
   endtask

   // Advance one edge, then sample; retire a queued result on done.
   task automatic step();
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
         n_done++;
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_done: got done=1 expected none");
         end else begin
            n_checks--;
            check("product", 32'(product), 32'(sb.pop_front()));
         end
      end
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      do begin
         step();
         lat++;
      end while (done !== 1'b1 && lat < 12);
      if (done !== 1'b1) sb.delete();
   endtask

   task automatic run_mult(input logic [3:0] a,
                           input logic [3:0] b,
                           input logic [7:0] exp);
      int lat;
      a_in  = a;
      b_in  = b;
      start = 1'b1;
      sb.push_back(exp);
      step();
      start = 1'b0;
      check("busy_after_start", 32'(busy), 1);
      wait_done(lat);
      check("latency", lat, 4);
      check("busy_at_done", 32'(busy), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int         lat;
      int         d0;
      logic [3:0] ea;
      logic [3:0] eb;
      logic [7:0] ep;

      vecs[0] = '{4'd11, 4'd14, 8'd154};
      vecs[1] = '{4'd15, 4'd15, 8'hE1};
      vecs[2] = '{4'd0,  4'd9,  8'd0};
      vecs[3] = '{4'd1,  4'd15, 8'd15};
      vecs[4] = '{4'd8,  4'd2,  8'd16};
      vecs[5] = '{4'd7,  4'd6,  8'd42};

      // Reset has priority over a pending start.
      rst   = 1'b1;
      start = 1'b1;
      a_in  = 4'd11;
      b_in  = 4'd14;
      step();
      step();
      check("rst_product", 32'(product), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      rst   = 1'b0;
      start = 1'b0;
      step();
      check("post_rst_busy", 32'(busy), 0);

      // Table vectors, each followed by a hold check.
      for (int i = 0; i < 6; i++) begin
         run_mult(vecs[i].a, vecs[i].b, vecs[i].p);
         a_in = ~vecs[i].a;
         b_in = ~vecs[i].b;
         step();
         step();
         check("hold_product", 32'(product), 32'(vecs[i].p));
         check("hold_done", 32'(done), 0);
      end

      // Start and operand changes while busy are ignored.
      a_in  = 4'd11;
      b_in  = 4'd14;
      start = 1'b1;
      sb.push_back(8'd154);
      step();
      d0   = n_done;
      a_in = 4'd3;
      b_in = 4'd3;
      wait_done(lat);
      start = 1'b0;
      check("intf_latency", lat, 4);
      repeat (6) step();
      check("intf_done_count", n_done - d0, 1);
      check("intf_busy", 32'(busy), 0);
      check("intf_hold", 32'(product), 154);

      // Reset in the second compute cycle aborts without done.
      a_in  = 4'd7;
      b_in  = 4'd6;
      start = 1'b1;
      step();
      start = 1'b0;
      check("abort_busy", 32'(busy), 1);
      step();
      d0  = n_done;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort_product", 32'(product), 0);
      check("abort_busy_clr", 32'(busy), 0);
      check("abort_done", 32'(done), 0);
      repeat (6) step();
      check("abort_no_done", n_done - d0, 0);
      run_mult(4'd7, 4'd6, 8'd42);

      // Back-to-back sweep: each start is raised in the done cycle.
      d0 = n_done;
      for (int i = 0; i < 256; i++) begin
         ea = 4'(i >> 4);
         eb = 4'(i);
         ep = {4'b0, ea} * {4'b0, eb};
         run_mult(ea, eb, ep);
      end
      check("sweep_done_count", n_done - d0, 256);
      repeat (3) step();
      check("sweep_idle", 32'(busy), 0);
      check("sb_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/day5_4bit_multiplier.md
Name: day5_4bit_multiplier

Overview:
Sequential unsigned 4x4 multiplier using a shift-and-add datapath. It produces an 8-bit product WIDTH cycles after a start request. It sits as a small arithmetic leaf block behind a start/done handshake. Operands are captured at start, so upstream may change a_in/b_in freely while the block is busy.

Parameters:
WIDTH, 4, operand width in bits; product width is 2*WIDTH. Only 4 is required to be verified; RTL stays generic.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
start  input  1  request a multiply; sampled only when idle
a_in  input  WIDTH  multiplicand, unsigned
b_in  input  WIDTH  multiplier, unsigned
product  output  2*WIDTH  registered result, unsigned
busy  output  1  high while a multiply is in progress
done  output  1  one-cycle pulse; product valid and updated

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset: sampled on the clk edge with rst=1. It forces state=IDLE, product=0, busy=0, done=0 and clears internal accumulator, operand and counter registers. rst has priority over start.
- States: IDLE, CALC.
- IDLE:
  - start=1 sampled at edge k: latch a_in into the multiplicand register (zero-extended to 2*WIDTH) and b_in into the multiplier shift register.
  - Also at edge k: clear the accumulator, set bit counter=0, busy=1, go to CALC.
  - start=0: hold. product keeps its last value.
- CALC, at each edge:
  - If multiplier LSB=1, add the multiplicand to the accumulator (2*WIDTH bits; no overflow is possible).
  - Shift the multiplicand left by 1 and the multiplier right by 1, then increment the counter.
- Completion:
  - On the edge that processes bit WIDTH-1 (edge k+WIDTH), load product with the final accumulator value, set done=1 and busy=0, and return to IDLE.
  - done is high for exactly one cycle and clears on the next edge.
- Latency: WIDTH edges from start acceptance to done (4 for WIDTH=4). Throughput is one multiply per WIDTH+1 cycles.
- start while busy: ignored, with no effect on the in-flight operation.
- Back-to-back: start=1 in the cycle where done=1 (state IDLE) is accepted on the next edge.
- Changes on a_in/b_in while busy do not affect the result.
- Reset mid-operation aborts the operation. No done is issued and product returns to 0.
- Product holds between operations; it changes only at completion or reset.
- Arithmetic: unsigned. Max result is (2^WIDTH-1)^2, which fits in 2*WIDTH bits. Zero operands still take the full WIDTH cycles (no early termination).

Decomposition:
- Shared package day5_mult_pkg holds:
  - the state enum typedef (IDLE, CALC);
  - localparam DEF_WIDTH=4;
  - a counter-width helper ($clog2(WIDTH)).
- No sub-module; a flat single-module FSM plus datapath is natural.

Test Plan:
- Reset: hold rst=1 for 2 cycles with start=1 -> product=0, busy=0, done=0, and no operation starts.
- Basic: a_in=4'b1011, b_in=4'b1110, start pulse -> busy for 4 cycles, done pulses on the 4th edge, product=8'b10011010 (154), and product holds afterwards.
- Corners: 15x15 -> 225 (8'hE1); 0x9 -> 0; 1x15 -> 15; 8x2 -> 16. Each shows done exactly 4 edges after start.
- Interference: start=1 and operand changes while busy (e.g. switch to 3x3 mid-operation) -> original 11x14=154 result is returned, and only one done pulse occurs.
- Abort: assert rst on the 2nd CALC cycle of 7x6 -> product=0, no done; a following start with 7x6 -> 42.
- Back-to-back and exhaustive: issue start in each done cycle for all 256 operand pairs -> every product equals a*b, with no lost or duplicated done pulses.
